// File: rtl/glyph_blitter.sv
// glyph_blitter
//   Walks the 8 rows of one glyph held in the 512x8 character ROM and turns
//   each row byte into per-pixel writes on a valid/ready stream.
//
//   Parameters
//     X_W        pixel x coordinate width
//     Y_W        pixel y coordinate width
//   Ports
//     clk        system clock, rising edge
//     reset      asynchronous, active-high; clears all state and outputs
//     start      request strobe, accepted only while idle
//     char_code  glyph index; ROM rows live at {char_code, row}
//     x, y       top-left pixel position of the glyph
//     opaque     1: emit all 64 pixels, 0: emit only set bits
//     busy       high whenever a glyph is in progress
//     done       one-cycle pulse when the glyph is complete
//     rom_addr   registered ROM address
//     rom_data   combinational ROM output for rom_addr
//     pix_valid  pixel write valid
//     pix_ready  downstream accepts pixel
//     pix_x      pixel column (wraps modulo 2^X_W)
//     pix_y      pixel row (wraps modulo 2^Y_W)
//     pix_on     glyph bit (1 = foreground)
module glyph_blitter #(
   parameter int X_W = 11,
   parameter int Y_W = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [5:0]     char_code,
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  logic           opaque,
   output logic           busy,
   output logic           done,
   output logic [8:0]     rom_addr,
   input  logic [7:0]     rom_data,
   output logic           pix_valid,
   input  logic           pix_ready,
   output logic [X_W-1:0] pix_x,
   output logic [Y_W-1:0] pix_y,
   output logic           pix_on
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EMIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]     state;
   logic [5:0]     code_q;
   logic [X_W-1:0] x_q;
   logic [Y_W-1:0] y_q;
   logic           opaque_q;
   logic [2:0]     row;
   logic [2:0]     col;
   logic [7:0]     row_buf;

   logic           cur_bit;
   logic           drawable;
   logic           advance;
   logic           emitting;

   // Column 0 is the MSB of the row byte (leftmost pixel).
   assign cur_bit  = row_buf[3'd7 - col];
   assign emitting = (state == S_EMIT);
   assign drawable = opaque_q | cur_bit;
   // A drawable column waits for the handshake; a blank one is skipped in a cycle.
   assign advance  = ~drawable | pix_ready;

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign pix_valid = emitting & drawable;
   assign pix_on    = emitting & cur_bit;
   assign pix_x     = emitting ? x_q + X_W'(col) : '0;
   assign pix_y     = emitting ? y_q + Y_W'(row) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         code_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         opaque_q <= 1'b0;
         row      <= '0;
         col      <= '0;
         row_buf  <= '0;
         rom_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  code_q   <= char_code;
                  x_q      <= x;
                  y_q      <= y;
                  opaque_q <= opaque;
                  row      <= '0;
                  col      <= '0;
                  rom_addr <= {char_code, 3'd0};
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               row_buf <= rom_data;
               col     <= '0;
               state   <= S_EMIT;
            end
            S_EMIT: begin
               if (advance) begin
                  if (col == 3'd7) begin
                     col <= '0;
                     if (row == 3'd7) begin
                        state <= S_DONE;
                     end else begin
                        row      <= row + 3'd1;
                        rom_addr <= {code_q, row + 3'd1};
                        state    <= S_FETCH;
                     end
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
